// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and next-PC selection, and talks to a req/ack
// instruction memory. It feeds {instruction, PC+4, valid} to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iPC_write,
    input  logic        iBranch_taken,
    input  logic [31:0] iBranch_target,
    input  logic        iJump,
    input  logic [25:0] iJumpAddr,
    input  logic        iJR,
    input  logic [31:0] iJR_target,
    input  logic        iInterrupt,
    input  logic        iException,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemAck,
    input  logic [31:0] iImemRData,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC_plus_4,
    output logic        oValid,
    output logic [31:0] oPC
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] hold_r;
    logic [31:0] pending_r;

    logic [31:0] pc_plus_4_s;
    logic [31:0] jump_target_s;
    logic [31:0] target_s;
    logic        redirect_s;

    assign pc_plus_4_s   = pc_r + 32'd4;
    assign jump_target_s = {pc_plus_4_s[31:28], iJumpAddr, 2'b00};
    assign redirect_s    = iException | iInterrupt | iBranch_taken | iJR | iJump;

    // Redirect target selection, highest priority first.
    always_comb begin
        target_s = pc_plus_4_s;
        if (iException) begin
            target_s = EXC_VECTOR;
        end else if (iInterrupt) begin
            target_s = INT_VECTOR;
        end else if (iBranch_taken) begin
            target_s = iBranch_target;
        end else if (iJR) begin
            target_s = iJR_target;
        end else if (iJump) begin
            target_s = jump_target_s;
        end else begin
            target_s = pc_plus_4_s;
        end
    end

    // PC, fetch state and the hold/pending buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r      <= RESET_PC;
            state_r   <= FETCH;
            hold_r    <= 32'h0;
            pending_r <= 32'h0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (redirect_s) begin
                        if (iImemAck) begin
                            pc_r <= target_s;
                        end else begin
                            // The outstanding request must still complete; its data is stale.
                            pending_r <= target_s;
                            state_r   <= DROP;
                        end
                    end else if (iImemAck) begin
                        if (iPC_write) begin
                            pc_r <= pc_plus_4_s;
                        end else begin
                            hold_r  <= iImemRData;
                            state_r <= HOLD;
                        end
                    end else begin
                        state_r <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect_s) begin
                        pc_r    <= target_s;
                        state_r <= FETCH;
                    end else if (iPC_write) begin
                        pc_r    <= pc_plus_4_s;
                        state_r <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                DROP: begin
                    if (iImemAck) begin
                        pc_r    <= redirect_s ? target_s : pending_r;
                        state_r <= FETCH;
                    end else if (redirect_s) begin
                        pending_r <= target_s;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= FETCH;
                end
            endcase
        end
    end

    // Memory request and IF/ID outputs; any redirect turns the slot into a nop.
    always_comb begin
        oImemReq     = 1'b0;
        oValid       = 1'b0;
        oInstruction = 32'h0;
        if (reset) begin
            oImemReq     = 1'b0;
            oValid       = 1'b0;
            oInstruction = 32'h0;
        end else begin
            case (state_r)
                FETCH: begin
                    oImemReq     = 1'b1;
                    oValid       = iImemAck & ~redirect_s & iPC_write;
                    oInstruction = oValid ? iImemRData : 32'h0;
                end
                HOLD: begin
                    oImemReq     = 1'b0;
                    oValid       = ~redirect_s;
                    oInstruction = oValid ? hold_r : 32'h0;
                end
                DROP: begin
                    oImemReq     = 1'b1;
                    oValid       = 1'b0;
                    oInstruction = 32'h0;
                end
                default: begin
                    oImemReq     = 1'b0;
                    oValid       = 1'b0;
                    oInstruction = 32'h0;
                end
            endcase
        end
    end

    assign oImemAddr  = pc_r;
    assign oPC        = pc_r;
    assign oPC_plus_4 = reset ? (RESET_PC + 32'd4) : pc_plus_4_s;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory responses are driven by hand each cycle.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        iPC_write;
    logic        iBranch_taken;
    logic [31:0] iBranch_target;
    logic        iJump;
    logic [25:0] iJumpAddr;
    logic        iJR;
    logic [31:0] iJR_target;
    logic        iInterrupt;
    logic        iException;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemRData;
    logic [31:0] oInstruction;
    logic [31:0] oPC_plus_4;
    logic        oValid;
    logic [31:0] oPC;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .iPC_write(iPC_write),
        .iBranch_taken(iBranch_taken), .iBranch_target(iBranch_target),
        .iJump(iJump), .iJumpAddr(iJumpAddr), .iJR(iJR), .iJR_target(iJR_target),
        .iInterrupt(iInterrupt), .iException(iException),
        .oImemReq(oImemReq), .oImemAddr(oImemAddr), .iImemAck(iImemAck),
        .iImemRData(iImemRData), .oInstruction(oInstruction),
        .oPC_plus_4(oPC_plus_4), .oValid(oValid), .oPC(oPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic pcw);
        iImemAck       = ack;
        iImemRData     = rdata;
        iPC_write      = pcw;
        iBranch_taken  = 1'b0;
        iBranch_target = 32'h0;
        iJump          = 1'b0;
        iJumpAddr      = 26'h0;
        iJR            = 1'b0;
        iJR_target     = 32'h0;
        iInterrupt     = 1'b0;
        iException     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        next_cycle();
        next_cycle();
        chk("rst_valid", {31'h0, oValid}, 32'h0);
        chk("rst_instr", oInstruction, 32'h0);
        chk("rst_pc4", oPC_plus_4, 32'h8000_0004);

        // Single-cycle memory: one instruction per cycle.
        reset = 1'b0;
        drive(1'b1, 32'h25A5_A5A5, 1'b1); #1;
        chk("seq0_req", {31'h0, oImemReq}, 32'h1);
        chk("seq0_addr", oImemAddr, 32'h8000_0000);
        chk("seq0_valid", {31'h0, oValid}, 32'h1);
        chk("seq0_instr", oInstruction, 32'h25A5_A5A5);
        chk("seq0_pc4", oPC_plus_4, 32'h8000_0004);
        next_cycle();
        drive(1'b1, 32'h25A5_A5A1, 1'b1); #1;
        chk("seq1_addr", oImemAddr, 32'h8000_0004);
        chk("seq1_valid", {31'h0, oValid}, 32'h1);
        chk("seq1_instr", oInstruction, 32'h25A5_A5A1);
        chk("seq1_pc4", oPC_plus_4, 32'h8000_0008);
        next_cycle();
        drive(1'b1, 32'h25A5_A5AD, 1'b1); #1;
        chk("seq2_addr", oImemAddr, 32'h8000_0008);
        chk("seq2_valid", {31'h0, oValid}, 32'h1);
        chk("seq2_pc4", oPC_plus_4, 32'h8000_000C);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("wait_addr", oImemAddr, 32'h8000_000C);
        chk("wait_valid", {31'h0, oValid}, 32'h0);
        chk("wait_instr", oInstruction, 32'h0);

        // Stall from ID: word at 80000004 is held and delivered exactly once.
        do_reset();
        drive(1'b1, 32'h25A5_A5A5, 1'b1); #1;
        chk("st0_valid", {31'h0, oValid}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h25A5_A5A1, 1'b0); #1;
        chk("st_ack_valid", {31'h0, oValid}, 32'h0);
        chk("st_ack_addr", oImemAddr, 32'h8000_0004);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0); #1;
            chk("hold_req", {31'h0, oImemReq}, 32'h0);
            chk("hold_valid", {31'h0, oValid}, 32'h1);
            chk("hold_instr", oInstruction, 32'h25A5_A5A1);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("rel_valid", {31'h0, oValid}, 32'h1);
        chk("rel_instr", oInstruction, 32'h25A5_A5A1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("post_rel_req", {31'h0, oImemReq}, 32'h1);
        chk("post_rel_addr", oImemAddr, 32'h8000_0008);
        chk("post_rel_valid", {31'h0, oValid}, 32'h0);
        next_cycle();

        // Three-cycle latency with a branch during the outstanding request.
        drive(1'b1, 32'h25A5_A5AD, 1'b1); #1;
        chk("lat_w8_valid", {31'h0, oValid}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("lat_req_addr", oImemAddr, 32'h8000_000C);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1);
        iBranch_taken  = 1'b1;
        iBranch_target = 32'h8000_0100; #1;
        chk("br_valid", {31'h0, oValid}, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("drop_req", {31'h0, oImemReq}, 32'h1);
        chk("drop_addr", oImemAddr, 32'h8000_000C);
        next_cycle();
        drive(1'b1, 32'h25A5_A5A9, 1'b1); #1;
        chk("drop_ack_addr", oImemAddr, 32'h8000_000C);
        chk("drop_ack_valid", {31'h0, oValid}, 32'h0);
        chk("drop_ack_instr", oInstruction, 32'h0);
        next_cycle();
        drive(1'b1, 32'h25A5_A4A5, 1'b1); #1;
        chk("br_tgt_addr", oImemAddr, 32'h8000_0100);
        chk("br_tgt_instr", oInstruction, 32'h25A5_A4A5);
        next_cycle();

        // Jump from 80000010, then exception beats branch.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (32'h8000_0000 + 32'(4 * i)) ^ 32'hA5A5_A5A5, 1'b1); #1;
            chk("pre_j_addr", oImemAddr, 32'h8000_0000 + 32'(4 * i));
            next_cycle();
        end
        drive(1'b1, 32'h25A5_A5B5, 1'b1);
        iJump     = 1'b1;
        iJumpAddr = 26'h000_0040; #1;
        chk("j_addr", oImemAddr, 32'h8000_0010);
        chk("j_suppress", {31'h0, oValid}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h0, 1'b1);
        iException     = 1'b1;
        iBranch_taken  = 1'b1;
        iBranch_target = 32'h8000_0200; #1;
        chk("j_tgt_addr", oImemAddr, 32'h8000_0100);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1);
        iInterrupt = 1'b1; #1;
        chk("exc_tgt_addr", oImemAddr, 32'h8000_0008);
        next_cycle();
        // Newest redirect in DROP replaces the pending interrupt target.
        drive(1'b0, 32'h0, 1'b1);
        iJR        = 1'b1;
        iJR_target = 32'h8000_0040; #1;
        chk("drop2_addr", oImemAddr, 32'h8000_0008);
        next_cycle();
        drive(1'b1, 32'h0, 1'b1); #1;
        chk("drop2_valid", {31'h0, oValid}, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1);
        iBranch_taken  = 1'b1;
        iBranch_target = 32'h8000_0300; #1;
        chk("newest_addr", oImemAddr, 32'h8000_0040);
        next_cycle();

        // Reset while in DROP discards the pending target.
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("rst_drop_valid", {31'h0, oValid}, 32'h0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("after_rst_pc", oPC, 32'h8000_0000);
        chk("after_rst_addr", oImemAddr, 32'h8000_0000);
        chk("after_rst_req", {31'h0, oImemReq}, 32'h1);
        chk("after_rst_valid", {31'h0, oValid}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h25A5_A5A5, 1'b1); #1;
        chk("after_rst_deliver", {31'h0, oValid}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h0, 1'b1);
        iJR        = 1'b1;
        iJR_target = 32'hFFFF_FFFC; #1;
        chk("no_pending_addr", oImemAddr, 32'h8000_0004);
        next_cycle();

        // PC+4 wraps modulo 2^32.
        drive(1'b1, 32'h5A5A_5A59, 1'b1); #1;
        chk("wrap_pc4", oPC_plus_4, 32'h0);
        chk("wrap_instr", oInstruction, 32'h5A5A_5A59);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1); #1;
        chk("wrap_addr", oImemAddr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC register and the next-PC selection: sequential, branch, jump, jr, interrupt and exception.
- Drives a req/ack instruction-memory port and tolerates multi-cycle memory latency.
- Presents {instruction, PC+4, valid} to IF/ID and inserts a nop (32'h0, valid=0) whenever no instruction is deliverable.

Parameters:
- RESET_PC, 32'h80000000, PC after reset.
- INT_VECTOR, 32'h80000004, interrupt entry.
- EXC_VECTOR, 32'h80000008, exception entry.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- iPC_write  in  1  from hazard unit; 0 = ID stalled, hold delivered instruction.
- iBranch_taken  in  1  one-cycle redirect pulse.
- iBranch_target  in  32  branch target.
- iJump  in  1  j/jal redirect pulse.
- iJumpAddr  in  26  instruction index.
- iJR  in  1  jr/jalr redirect pulse.
- iJR_target  in  32  register target.
- iInterrupt  in  1  redirect to INT_VECTOR.
- iException  in  1  redirect to EXC_VECTOR.
- oImemReq  out  1  fetch request.
- oImemAddr  out  32  fetch address (word aligned).
- iImemAck  in  1  iImemRData valid this cycle; only meaningful while oImemReq=1.
- iImemRData  in  32  fetched word.
- oInstruction  out  32  to IF/ID; 32'h0 when oValid=0.
- oPC_plus_4  out  32  PC+4 of oInstruction.
- oValid  out  1  oInstruction is a real fetched instruction.
- oPC  out  32  current fetch PC (EPC source).

Behaviour:
- State registers: PC, state ∈ {FETCH, HOLD, DROP}, hold buffer (32b), pending target (32b).
- Reset (sync, dominant over all inputs): PC=RESET_PC, state=FETCH, buffers cleared. The cycle after reset: oImemReq=1, oImemAddr=RESET_PC. While reset is high: oValid=0, oInstruction=0, oPC_plus_4=RESET_PC+4. The instruction memory shares this reset, so no response survives reset.
- Redirect = OR of the five redirect inputs. Target priority: exception > interrupt > branch > jr > jump.
- Jump target = {PC_plus_4[31:28], iJumpAddr, 2'b00}, so PC[31] (kernel bit) is preserved.
- PC+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 0.
- oImemAddr = PC in every state; it is held stable while oImemReq=1.
- FETCH: oImemReq=1.
  - ack & no redirect & iPC_write=1: oValid=1, oInstruction=rdata combinationally; PC<=PC+4; stay FETCH. With a single-cycle-ack memory this gives 1 instr/cycle.
  - ack & no redirect & iPC_write=0: oValid=0; hold buffer<=rdata; PC unchanged; go HOLD.
  - redirect & ack: data dropped, oValid=0; PC<=target; stay FETCH.
  - redirect & no ack: oValid=0; pending<=target; go DROP.
  - no ack, no redirect: oValid=0; wait.
- HOLD: oImemReq=0; oValid=1, oInstruction=buffer.
  - redirect: oValid forced 0; PC<=target; go FETCH.
  - iPC_write=1: delivered; PC<=PC+4; go FETCH.
  - else: stay HOLD.
- DROP: oImemReq=1 at the old address; oValid=0.
  - A new redirect overwrites pending (newest wins).
  - On ack: data discarded; PC<=pending, or the new target if a redirect arrives in the same cycle; go FETCH.
- A redirect in the same cycle as a delivery always suppresses the delivery (oValid=0). The redirecting instruction is already in ID/EX; the wrong-path slot becomes a nop.
- oPC_plus_4 = PC+4 in all states.
- No instruction is ever delivered twice or skipped.

Test Plan:
- Reset, then ack every cycle with rdata=addr^32'hA5A5A5A5 -> oImemAddr 80000000, 80000004, 80000008 on consecutive cycles; oValid=1 each cycle; oPC_plus_4 = addr+4.
- Ack at 80000004 while iPC_write=0 for 3 cycles -> HOLD, oImemReq=0, oInstruction constant and valid. On release, the next cycle requests 80000008; the word is delivered exactly once.
- 3-cycle-latency memory; assert iBranch_taken (target 80000100) in the cycle after req at 8000000C -> req stays at 8000000C until ack, that data is dropped (oValid=0), and the next req is 80000100.
- iJump with iJumpAddr=26'h0000040 while PC=80000010 -> next PC 80000100. Then iException and iBranch_taken in the same cycle -> next PC 80000008.
- Reset asserted mid-DROP -> next cycle PC=80000000, state FETCH, pending target discarded, oValid=0.
